// File: rtl/ppg_calib_pkg.sv
// ============================================================================
// ppg_calib_pkg : shared widths, thresholds and FSM states for the PPG calibration controller
// Revision      : 1.0
// ============================================================================
`default_nettype none

package ppg_calib_pkg;

   localparam int DC_W   = 7;
   localparam int GAIN_W = 4;
   localparam int ADC_W  = 8;
   localparam int CNT_W  = 8;
   localparam int IDX_W  = 3;

   localparam logic [ADC_W-1:0] TARGET_DEF     = 8'd128;
   localparam logic [ADC_W-1:0] PEAK_LIMIT_DEF = 8'd224;

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      DC_SET  = 4'd1,
      DC_WAIT = 4'd2,
      DC_DEC  = 4'd3,
      G_SET   = 4'd4,
      G_WAIT  = 4'd5,
      G_PEAK  = 4'd6,
      G_DEC   = 4'd7,
      DONE    = 4'd8
   } state_t;

endpackage

`default_nettype wire

// File: rtl/ppg_calib_controller_sar_step.sv
// ============================================================================
// sar_step : generic N-bit successive-approximation register, MSB first
// Revision : 1.0
// ============================================================================
`default_nettype none

module sar_step
   import ppg_calib_pkg::*;
#(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         set_bit,
   input  logic         decide,
   input  logic         keep,
   output logic [W-1:0] code,
   output logic         last
);

   logic [W-1:0]     code_q, code_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [W-1:0]     mask;

   assign mask = W'(1) << idx_q;

   always_comb begin
      code_d = code_q;
      idx_d  = idx_q;
      if (clr) begin
         code_d = '0;
         idx_d  = IDX_W'(W - 1);
      end else if (set_bit) begin
         code_d = code_q | mask;
      end else if (decide) begin
         if (!keep) code_d = code_q & ~mask;
         // Hold at bit 0 so the index never wraps; clr reloads it.
         if (idx_q != '0) idx_d = idx_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         code_q <= '0;
         idx_q  <= IDX_W'(W - 1);
      end else begin
         code_q <= code_d;
         idx_q  <= idx_d;
      end
   end

   assign code = code_q;
   assign last = (idx_q == '0);

endmodule

`default_nettype wire

// File: rtl/ppg_calib_controller.sv
// ============================================================================
// ppg_calib_controller : SAR calibration of DC compensation then PGA gain
// Revision             : 1.0
// ============================================================================
`default_nettype none

module ppg_calib_controller
   import ppg_calib_pkg::*;
#(
   parameter int               SETTLE_CYC = 4,
   parameter int               PEAK_WIN   = 8,
   parameter logic [ADC_W-1:0] TARGET     = TARGET_DEF,
   parameter logic [ADC_W-1:0] PEAK_LIMIT = PEAK_LIMIT_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              ch_sel,
   input  logic              abort,
   input  logic [ADC_W-1:0]  vppg,
   output logic [DC_W-1:0]   dc_comp,
   output logic [GAIN_W-1:0] pga_gain,
   output logic              led_red,
   output logic              led_ir,
   output logic              busy,
   output logic              done,
   output logic              dc_sat
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] settle_q, settle_d;
   logic [CNT_W-1:0] peak_q, peak_d;
   logic [ADC_W-1:0] max_q, max_d;
   logic             ch_q, ch_d;
   logic             sat_q, sat_d;

   logic sar_clr, dc_set, dc_dec, g_set, g_dec;
   logic dc_last, g_last;

   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      peak_d   = peak_q;
      max_d    = max_q;
      ch_d     = ch_q;
      sat_d    = sat_q;
      sar_clr  = 1'b0;
      dc_set   = 1'b0;
      dc_dec   = 1'b0;
      g_set    = 1'b0;
      g_dec    = 1'b0;

      if (abort && state_q != IDLE) begin
         state_d = IDLE;
         sar_clr = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (start && !abort) begin
                  ch_d    = ch_sel;
                  sat_d   = 1'b0;
                  sar_clr = 1'b1;
                  state_d = DC_SET;
               end
            end
            DC_SET: begin
               dc_set   = 1'b1;
               settle_d = CNT_W'(SETTLE_CYC - 1);
               state_d  = DC_WAIT;
            end
            DC_WAIT: begin
               if (settle_q == '0) state_d = DC_DEC;
               else                settle_d = settle_q - 1'b1;
            end
            DC_DEC: begin
               dc_dec  = 1'b1;
               state_d = dc_last ? G_SET : DC_SET;
            end
            G_SET: begin
               g_set    = 1'b1;
               settle_d = CNT_W'(SETTLE_CYC - 1);
               peak_d   = CNT_W'(PEAK_WIN - 1);
               max_d    = '0;
               state_d  = G_WAIT;
            end
            G_WAIT: begin
               if (settle_q == '0) state_d = G_PEAK;
               else                settle_d = settle_q - 1'b1;
            end
            G_PEAK: begin
               if (vppg > max_q) max_d = vppg;
               if (peak_q == '0) state_d = G_DEC;
               else              peak_d = peak_q - 1'b1;
            end
            G_DEC: begin
               g_dec = 1'b1;
               if (g_last) begin
                  // DC code is frozen during the gain search, so saturation is final here.
                  sat_d   = (dc_comp == '0) || (dc_comp == '1);
                  state_d = DONE;
               end else begin
                  state_d = G_SET;
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         settle_q <= '0;
         peak_q   <= '0;
         max_q    <= '0;
         ch_q     <= 1'b0;
         sat_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         peak_q   <= peak_d;
         max_q    <= max_d;
         ch_q     <= ch_d;
         sat_q    <= sat_d;
      end
   end

   sar_step #(.W(DC_W)) u_dc_sar (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (sar_clr),
      .set_bit (dc_set),
      .decide  (dc_dec),
      .keep    (vppg >= TARGET),
      .code    (dc_comp),
      .last    (dc_last)
   );

   sar_step #(.W(GAIN_W)) u_gain_sar (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (sar_clr),
      .set_bit (g_set),
      .decide  (g_dec),
      .keep    (max_q <= PEAK_LIMIT),
      .code    (pga_gain),
      .last    (g_last)
   );

   assign busy    = (state_q != IDLE);
   assign done    = (state_q == DONE);
   assign led_red = busy & ~ch_q;
   assign led_ir  = busy & ch_q;
   assign dc_sat  = sat_q;

endmodule

`default_nettype wire
